// File: rtl/axis_frame_len_stats.sv
// Passive AXI-Stream frame length monitor with saturating byte count,
// oversize policing against MAX_LEN and clearable count/min/max statistics.
module axis_frame_len_stats #(
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEEP_WIDTH-1:0]  monitor_axis_tkeep,
  input  logic                   monitor_axis_tvalid,
  input  logic                   monitor_axis_tready,
  input  logic                   monitor_axis_tlast,
  input  logic                   stats_clear,
  output logic [LEN_WIDTH-1:0]   frame_len,
  output logic                   frame_len_valid,
  output logic                   frame_oversize,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [LEN_WIDTH-1:0]   min_len,
  output logic [LEN_WIDTH-1:0]   max_len
);

  localparam int BEAT_W = $clog2(KEEP_WIDTH) + 1;
  localparam int SUM_W  = LEN_WIDTH + 1;

  logic [LEN_WIDTH-1:0]   acc;
  // Remembers that the running total already clipped, so a later beat that
  // adds nothing still reports the frame as oversize.
  logic                   acc_sat;

  logic                   xfer;
  logic [BEAT_W-1:0]      beat_bytes;
  logic [SUM_W-1:0]       sum_wide;
  logic [LEN_WIDTH-1:0]   beat_sum;
  logic                   sat_total;
  logic                   over;
  logic [COUNT_WIDTH-1:0] cnt_base;
  logic [LEN_WIDTH-1:0]   min_base;
  logic [LEN_WIDTH-1:0]   max_base;

  assign xfer = monitor_axis_tvalid && monitor_axis_tready;

  // NOTE: every always_comb output gets a default first so no latch is inferred;
  // combinational logic uses blocking '=', registers below use non-blocking '<='.
  always_comb begin
    beat_bytes = '0;
    if (KEEP_ENABLE) begin
      for (int i = 0; i < KEEP_WIDTH; i++)
        beat_bytes = beat_bytes + BEAT_W'(monitor_axis_tkeep[i]);
    end else begin
      beat_bytes = BEAT_W'(KEEP_WIDTH);
    end
  end

  always_comb begin
    sum_wide  = {1'b0, acc} + SUM_W'(beat_bytes);
    sat_total = acc_sat || sum_wide[LEN_WIDTH];
    beat_sum  = sum_wide[LEN_WIDTH] ? '1 : sum_wide[LEN_WIDTH-1:0];
    over      = sat_total || (64'(sum_wide) > 64'(MAX_LEN));
  end

  // Clear is applied first so a frame completing in the same cycle lands on
  // freshly cleared statistics.
  always_comb begin
    cnt_base = stats_clear ? '0 : frame_count;
    min_base = stats_clear ? '1 : min_len;
    max_base = stats_clear ? '0 : max_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      acc_sat         <= 1'b0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      frame_oversize  <= 1'b0;
      frame_count     <= '0;
      min_len         <= '1;
      max_len         <= '0;
    end else begin
      frame_len_valid <= 1'b0;
      frame_count     <= cnt_base;
      min_len         <= min_base;
      max_len         <= max_base;
      if (xfer) begin
        if (monitor_axis_tlast) begin
          frame_len       <= beat_sum;
          frame_oversize  <= over;
          frame_len_valid <= 1'b1;
          acc             <= '0;
          acc_sat         <= 1'b0;
          frame_count     <= (&cnt_base) ? cnt_base : cnt_base + COUNT_WIDTH'(1);
          min_len         <= (beat_sum < min_base) ? beat_sum : min_base;
          max_len         <= (beat_sum > max_base) ? beat_sum : max_base;
        end else begin
          acc     <= beat_sum;
          acc_sat <= sat_total;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Bench for axis_frame_len_stats: a 64-bit tkeep-counting instance (8-bit length,
// MAX_LEN 100) and an 8-bit fixed-beat instance share one handshake.
module tb_axis_frame_len_stats;

  logic        clk = 1'b0;
  logic        rst, tvalid, tready, tlast, clear;
  logic [7:0]  keep_a;
  logic        keep_b;

  logic [7:0]  len_a, min_a, max_a;
  logic        vld_a, ov_a;
  logic [31:0] cnt_a;
  logic [15:0] len_b, min_b, max_b;
  logic        vld_b, ov_b;
  logic [31:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_frame_len_stats #(
    .DATA_WIDTH(64), .LEN_WIDTH(8), .COUNT_WIDTH(32), .MAX_LEN(100)
  ) u_a (
    .clk(clk), .rst(rst), .monitor_axis_tkeep(keep_a), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .stats_clear(clear),
    .frame_len(len_a), .frame_len_valid(vld_a), .frame_oversize(ov_a),
    .frame_count(cnt_a), .min_len(min_a), .max_len(max_a)
  );

  axis_frame_len_stats #(
    .DATA_WIDTH(8), .KEEP_ENABLE(1'b0), .LEN_WIDTH(16), .COUNT_WIDTH(32), .MAX_LEN(20)
  ) u_b (
    .clk(clk), .rst(rst), .monitor_axis_tkeep(keep_b), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .stats_clear(clear),
    .frame_len(len_b), .frame_len_valid(vld_b), .frame_oversize(ov_b),
    .frame_count(cnt_b), .min_len(min_b), .max_len(max_b)
  );

  // Reference model: unbounded byte totals per frame, clipped only when reported.
  longint acc_a, acc_b;
  longint m_len_a, m_cnt_a, m_min_a, m_max_a;
  longint m_len_b, m_cnt_b, m_min_b, m_max_b;
  bit     m_vld, m_ov_a, m_ov_b;

  task automatic model_reset();
    acc_a = 0; acc_b = 0; m_vld = 0;
    m_len_a = 0; m_ov_a = 0; m_cnt_a = 0; m_min_a = 255;   m_max_a = 0;
    m_len_b = 0; m_ov_b = 0; m_cnt_b = 0; m_min_b = 65535; m_max_b = 0;
  endtask

  task automatic model_frame_done();
    m_vld   = 1;
    m_len_a = (acc_a > 255) ? 255 : acc_a;
    m_ov_a  = (acc_a > 100);
    if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
    if (m_len_a < m_min_a) m_min_a = m_len_a;
    if (m_len_a > m_max_a) m_max_a = m_len_a;
    m_len_b = (acc_b > 65535) ? 65535 : acc_b;
    m_ov_b  = (acc_b > 20);
    if (m_cnt_b < 64'hFFFF_FFFF) m_cnt_b++;
    if (m_len_b < m_min_b) m_min_b = m_len_b;
    if (m_len_b > m_max_b) m_max_b = m_len_b;
    acc_a = 0; acc_b = 0;
  endtask

  function automatic logic [57:0] exp_a();
    return {m_vld, 8'(m_len_a), m_ov_a, 32'(m_cnt_a), 8'(m_min_a), 8'(m_max_a)};
  endfunction

  function automatic logic [81:0] exp_b();
    return {m_vld, 16'(m_len_b), m_ov_b, 32'(m_cnt_b), 16'(m_min_b), 16'(m_max_b)};
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit.
  task automatic step(input bit v, input bit r, input bit l, input bit c, input bit rs,
                      input logic [7:0] ka);
    tvalid = v; tready = r; tlast = l; clear = c; rst = rs; keep_a = ka; keep_b = ka[0];
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (c) begin
        m_cnt_a = 0; m_min_a = 255;   m_max_a = 0;
        m_cnt_b = 0; m_min_b = 65535; m_max_b = 0;
      end
      m_vld = 0;
      if (v && r) begin
        acc_a += $countones(ka);
        acc_b += 1;
        if (l) model_frame_done();
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);
    total++;
    if ({vld_a, len_a, ov_a, cnt_a, min_a, max_a} !== {1'b0, 8'd0, 1'b0, 32'd0, 8'hFF, 8'd0}) begin
      bad++;
      $display("FAIL reset_a got=%h want=%h", {vld_a, len_a, ov_a, cnt_a, min_a, max_a},
               {1'b0, 8'd0, 1'b0, 32'd0, 8'hFF, 8'd0});
    end
    total++;
    if ({vld_b, len_b, ov_b, cnt_b, min_b, max_b} !== {1'b0, 16'd0, 1'b0, 32'd0, 16'hFFFF, 16'd0}) begin
      bad++;
      $display("FAIL reset_b got=%h want=%h", {vld_b, len_b, ov_b, cnt_b, min_b, max_b},
               {1'b0, 16'd0, 1'b0, 32'd0, 16'hFFFF, 16'd0});
    end
  endtask

  task automatic test_stall_frame();
    step(1, 0, 1, 0, 0, 8'h01);   // stalled tlast must be ignored
    total++;
    if ({vld_a, cnt_a} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL stall_ignored got vld=%b cnt=%0d want vld=0 cnt=0", vld_a, cnt_a);
    end
    step(1, 1, 0, 0, 0, 8'h01);
    step(1, 1, 1, 0, 0, 8'h01);
    total++;
    if ({vld_a, len_a, cnt_a, min_a, max_a} !== {1'b1, 8'd2, 32'd1, 8'd2, 8'd2}) begin
      bad++; $display("FAIL stall_frame_a got=%h want=%h", {vld_a, len_a, cnt_a, min_a, max_a},
                      {1'b1, 8'd2, 32'd1, 8'd2, 8'd2});
    end
    total++;
    if ({vld_b, len_b, cnt_b, min_b, max_b} !== {1'b1, 16'd2, 32'd1, 16'd2, 16'd2}) begin
      bad++; $display("FAIL stall_frame_b got=%h want=%h", {vld_b, len_b, cnt_b, min_b, max_b},
                      {1'b1, 16'd2, 32'd1, 16'd2, 16'd2});
    end
    idle();
    total++;
    if ({vld_a, len_a} !== {1'b0, 8'd2}) begin
      bad++; $display("FAIL valid_one_cycle got vld=%b len=%0d want vld=0 len=2", vld_a, len_a);
    end
  endtask

  task automatic test_partial_keep();
    step(1, 1, 0, 0, 0, 8'hFF);
    step(1, 1, 0, 0, 0, 8'hFF);
    step(1, 1, 1, 0, 0, 8'h07);
    total++;
    if ({len_a, ov_a, cnt_a, min_a, max_a} !== {8'd19, 1'b0, 32'd2, 8'd2, 8'd19}) begin
      bad++; $display("FAIL partial_keep got=%h want=%h", {len_a, ov_a, cnt_a, min_a, max_a},
                      {8'd19, 1'b0, 32'd2, 8'd2, 8'd19});
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 8'hFF);
    step(1, 1, 1, 0, 1, 8'hFF);   // tlast transfer during reset is dropped
    total++;
    if ({vld_a, len_a, ov_a, cnt_a, min_a, max_a} !== {1'b0, 8'd0, 1'b0, 32'd0, 8'hFF, 8'd0}) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", {vld_a, len_a, ov_a, cnt_a, min_a, max_a},
                      {1'b0, 8'd0, 1'b0, 32'd0, 8'hFF, 8'd0});
    end
    step(1, 1, 1, 0, 0, 8'h01);
    total++;
    if ({vld_a, len_a, cnt_a, len_b, cnt_b} !== {1'b1, 8'd1, 32'd1, 16'd1, 32'd1}) begin
      bad++; $display("FAIL after_reset_frame got=%h want=%h", {vld_a, len_a, cnt_a, len_b, cnt_b},
                      {1'b1, 8'd1, 32'd1, 16'd1, 32'd1});
    end
  endtask

  task automatic test_oversize_sat();
    step(0, 0, 0, 1, 0, 8'h00);
    total++;
    if ({len_a, cnt_a, min_a, max_a} !== {8'd1, 32'd0, 8'hFF, 8'd0}) begin
      bad++; $display("FAIL clear got=%h want=%h", {len_a, cnt_a, min_a, max_a}, {8'd1, 32'd0, 8'hFF, 8'd0});
    end
    for (int i = 0; i < 40; i++) step(1, 1, (i == 39), 0, 0, 8'hFF);
    total++;
    if ({len_a, ov_a, cnt_a, min_a, max_a} !== {8'd255, 1'b1, 32'd1, 8'd255, 8'd255}) begin
      bad++; $display("FAIL saturate got=%h want=%h", {len_a, ov_a, cnt_a, min_a, max_a},
                      {8'd255, 1'b1, 32'd1, 8'd255, 8'd255});
    end
    total++;
    if ({len_b, ov_b} !== {16'd40, 1'b1}) begin
      bad++; $display("FAIL oversize_b got len=%0d ov=%b want len=40 ov=1", len_b, ov_b);
    end
    for (int i = 0; i < 8; i++) step(1, 1, (i == 7), 0, 0, 8'hFF);
    total++;
    if ({len_a, ov_a, cnt_a, min_a, max_a} !== {8'd64, 1'b0, 32'd2, 8'd64, 8'd255}) begin
      bad++; $display("FAIL after_oversize got=%h want=%h", {len_a, ov_a, cnt_a, min_a, max_a},
                      {8'd64, 1'b0, 32'd2, 8'd64, 8'd255});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] keeps [3];
    logic [7:0] lens  [3];
    keeps = '{8'h01, 8'hFF, 8'h07};
    lens  = '{8'd1, 8'd8, 8'd3};
    step(0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, keeps[i]);
      total++;
      if ({vld_a, len_a} !== {1'b1, lens[i]}) begin
        bad++; $display("FAIL b2b_frame%0d got vld=%b len=%0d want vld=1 len=%0d", i, vld_a, len_a, lens[i]);
      end
    end
    total++;
    if ({cnt_a, min_a, max_a, cnt_b, min_b, max_b} !== {32'd3, 8'd1, 8'd8, 32'd3, 16'd1, 16'd1}) begin
      bad++; $display("FAIL b2b_stats got=%h want=%h", {cnt_a, min_a, max_a, cnt_b, min_b, max_b},
                      {32'd3, 8'd1, 8'd8, 32'd3, 16'd1, 16'd1});
    end
  endtask

  task automatic test_clear_collision();
    step(1, 1, 1, 1, 0, 8'h1F);
    total++;
    if ({vld_a, len_a, cnt_a, min_a, max_a} !== {1'b1, 8'd5, 32'd1, 8'd5, 8'd5}) begin
      bad++; $display("FAIL clear_collision got=%h want=%h", {vld_a, len_a, cnt_a, min_a, max_a},
                      {1'b1, 8'd5, 32'd1, 8'd5, 8'd5});
    end
    total++;
    if ({cnt_b, min_b, max_b} !== {32'd1, 16'd1, 16'd1}) begin
      bad++; $display("FAIL clear_collision_b got=%h want=%h", {cnt_b, min_b, max_b}, {32'd1, 16'd1, 16'd1});
    end
    idle();
  endtask

  task automatic test_random();
    int last_pct;
    logic [7:0] ka;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) last_pct = ($urandom_range(0, 1) == 0) ? 3 : 30;
      ka = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < last_pct, $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) == 0, ka);
      total++;
      if ({vld_a, len_a, ov_a, cnt_a, min_a, max_a} !== exp_a()) begin
        bad++; $display("FAIL random_a cycle=%0d got=%h want=%h", n,
                        {vld_a, len_a, ov_a, cnt_a, min_a, max_a}, exp_a());
      end
      total++;
      if ({vld_b, len_b, ov_b, cnt_b, min_b, max_b} !== exp_b()) begin
        bad++; $display("FAIL random_b cycle=%0d got=%h want=%h", n,
                        {vld_b, len_b, ov_b, cnt_b, min_b, max_b}, exp_b());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall_frame();
    test_partial_keep();
    test_reset_mid_frame();
    test_oversize_sat();
    test_back_to_back();
    test_clear_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_len_stats.md
Name: axis_frame_len_stats

Overview:
Passive AXI-Stream monitor that measures the byte length of every frame seen on a tapped link and keeps running statistics: frame count, minimum and maximum length, and an oversize flag. It is the successor of the single-frame length monitor. It adds configurable byte-count saturation, a MAX_LEN policing threshold, and a clearable statistics block. It sits beside any AXI-Stream interface in the datapath and never drives the handshake.

Parameters:
DATA_WIDTH, 64, monitored tdata width in bits (multiple of 8)
KEEP_ENABLE, (DATA_WIDTH>8), 1 = count bytes from tkeep; 0 = every beat carries KEEP_WIDTH bytes
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
LEN_WIDTH, 16, width of length and min/max outputs
COUNT_WIDTH, 32, width of frame counter
MAX_LEN, 1518, frames with length > MAX_LEN flag oversize

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
monitor_axis_tkeep  input  KEEP_WIDTH  byte enables of monitored beat
monitor_axis_tvalid  input  1  monitored tvalid
monitor_axis_tready  input  1  monitored tready
monitor_axis_tlast  input  1  monitored tlast
stats_clear  input  1  synchronous clear of statistics (1-cycle pulse or level)
frame_len  output  LEN_WIDTH  byte length of last completed frame
frame_len_valid  output  1  one-cycle pulse: frame_len/frame_oversize updated
frame_oversize  output  1  last completed frame length > MAX_LEN
frame_count  output  COUNT_WIDTH  completed frames since reset/clear
min_len  output  LEN_WIDTH  smallest completed frame length
max_len  output  LEN_WIDTH  largest completed frame length

Behaviour:
- Transfer = tvalid && tready. Beats with tvalid=1, tready=0 (or tready=1, tvalid=0) are ignored entirely, including tlast.
- Beat bytes: KEEP_ENABLE ? popcount(tkeep) : KEEP_WIDTH. Use a (clog2(KEEP_WIDTH)+1)-bit adder. tkeep=0 contributes 0.
- Internal accumulator acc (LEN_WIDTH), reset 0.
- Beat sum = acc + beat bytes, saturating at 2^LEN_WIDTH-1. It never wraps.
- Non-last transfer: acc <= beat sum.
- Last transfer, registered on the same edge:
  - frame_len <= beat sum
  - frame_oversize <= (unsaturated total > MAX_LEN); a saturated total counts as oversize
  - frame_len_valid <= 1
  - acc <= 0
- Latency: frame_len_valid is high exactly one cycle, the cycle after the tlast transfer edge. Back-to-back single-beat frames produce consecutive pulses.
- frame_len and frame_oversize hold their values until the next frame completes.
- Statistics update on the same edge as frame_len:
  - frame_count +1, saturating at all-ones
  - min_len <= min(min_len, len)
  - max_len <= max(max_len, len)
- Zero-length frames (all tkeep=0) are reported and counted, with len=0.
- stats_clear: frame_count <= 0, min_len <= all-ones, max_len <= 0. acc, frame_len and frame_oversize are unaffected.
- If stats_clear coincides with a frame completion, the completing frame is applied after the clear: frame_count=1, min_len=max_len=len.
- rst (synchronous, priority over everything):
  - acc=0, frame_len=0, frame_len_valid=0, frame_oversize=0
  - frame_count=0, min_len=all-ones, max_len=0
- A partial frame in flight at reset is discarded. The next frame counts from 0. A tlast transfer in the reset cycle is ignored.
- No reset-dependent X: every register has an explicit reset value.
- No state machine beyond in-frame/idle implied by acc. No backpressure generated.

Test Plan:
- Single-beat stall then frame (DATA_WIDTH=8, KEEP_ENABLE=0):
  - stimulus: tvalid=1, tready=0 for 1 cycle, then 2 transfers, the 2nd with tlast
  - response: frame_len=2, frame_len_valid pulses once, frame_count=1, min=max=2
- Partial tkeep (DATA_WIDTH=64):
  - stimulus: beats tkeep=0xFF, 0xFF, 0x07 with tlast
  - response: frame_len=19, frame_oversize=0
- Reset mid-frame:
  - stimulus: 3 transfers of 8 bytes, rst for 1 cycle, then a 1-beat frame tkeep=0x01, tlast
  - response: frame_len=1 (not 25), frame_count=1
- Oversize and saturation:
  - stimulus: LEN_WIDTH=8, MAX_LEN=100; a 40-beat 8-byte frame
  - response: frame_len=255, frame_oversize=1
  - stimulus: next frame of 64 bytes
  - response: frame_oversize=0, min_len=64, max_len=255
- Back-to-back and clear collision:
  - stimulus: frames of 1, 8, 3 bytes on consecutive cycles
  - response: three consecutive valid pulses, count=3, min=1, max=8
  - stimulus: stats_clear asserted on the tlast edge of a 5-byte frame
  - response: count=1, min=max=5
